// File: rtl/dma_ext_device_if.sv
// ============================================================================
//  Module   : dma_ext_device_if
//  Brief    : Bus bundle between dma_ext_device and its environment
//             (buffer load, interrupt/length, grant/offset, memory write).
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface dma_ext_device_if #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_WORDS = 12,
  parameter int ADDR_W    = $clog2(NUM_WORDS)
);

  // Host-side buffer load and transfer start
  logic                  start;
  logic                  buf_we;
  logic [ADDR_W-1:0]     buf_waddr;
  logic [WORD_SIZE-1:0]  buf_wdata;

  // Request towards dma_controller
  logic                  interrupt;
  logic [WORD_SIZE-1:0]  length;

  // Grant and block offset from the arbiter / dma_controller
  logic                  bg;
  logic [WORD_SIZE-1:0]  offset;

  // Memory write handshake
  logic [WORD_SIZE-1:0]  dev_data;
  logic [1:0]            dev_beat;
  logic                  dev_wr_req;
  logic                  dev_wr_ack;

  // Status
  logic                  block_done;
  logic                  busy;
  logic                  err;

  // The device itself
  modport slave (
    input  start, buf_we, buf_waddr, buf_wdata, bg, offset, dev_wr_ack,
    output interrupt, length, dev_data, dev_beat, dev_wr_req,
           block_done, busy, err
  );

  // Whatever drives the device (controller, arbiter, memory, host)
  modport master (
    output start, buf_we, buf_waddr, buf_wdata, bg, offset, dev_wr_ack,
    input  interrupt, length, dev_data, dev_beat, dev_wr_req,
           block_done, busy, err
  );

endinterface

`default_nettype wire

// File: rtl/dma_ext_device.sv
// ============================================================================
//  Module   : dma_ext_device
//  Brief    : External I/O device for dma_controller. Buffers NUM_WORDS words,
//             requests a transfer with a one-cycle interrupt, then streams one
//             BLOCK_WORDS block per bus grant at the offset supplied by the
//             controller, pulsing block_done after each block.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dma_ext_device #(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_WORDS   = 12,
  parameter int BLOCK_WORDS = 4
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  dma_ext_device_if.slave  bus
);

  localparam int ADDR_W     = $clog2(NUM_WORDS);
  localparam int NUM_BLOCKS = NUM_WORDS / BLOCK_WORDS;
  localparam int BLK_W      = $clog2(NUM_BLOCKS + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IRQ      = 3'd1,
    S_WAIT_GNT = 3'd2,
    S_SYNC     = 3'd3,
    S_XFER     = 3'd4,
    S_DONE_BLK = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  interrupt_q, interrupt_d;
  logic [WORD_SIZE-1:0]  length_q, length_d;
  logic [WORD_SIZE-1:0]  dev_data_q, dev_data_d;
  logic [1:0]            dev_beat_q, dev_beat_d;
  logic                  dev_wr_req_q, dev_wr_req_d;
  logic                  block_done_q, block_done_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [BLK_W-1:0]      blocks_sent_q, blocks_sent_d;
  // Set when a grant was already high on entry to WAIT_GNT; bg must fall
  // before a new grant is recognised so one grant moves only one block.
  logic                  need_low_q, need_low_d;

  logic [WORD_SIZE-1:0]  mem_q [NUM_WORDS];

  logic [ADDR_W-1:0]     w_sync_addr;
  logic [ADDR_W-1:0]     w_next_addr;
  logic                  w_out_of_range;
  logic                  w_accept;
  logic                  w_last_beat;

  assign w_sync_addr    = bus.offset[ADDR_W-1:0];
  assign w_next_addr    = base_q + ADDR_W'(dev_beat_q) + ADDR_W'(1);
  assign w_out_of_range = ({1'b0, bus.offset} + (WORD_SIZE+1)'(BLOCK_WORDS))
                          > (WORD_SIZE+1)'(NUM_WORDS);
  assign w_accept       = dev_wr_req_q && bus.dev_wr_ack;
  assign w_last_beat    = (dev_beat_q == 2'(BLOCK_WORDS - 1));

  // Buffer load port; only accepted while idle, contents survive reset
  always_ff @(posedge clk) begin
    if (bus.buf_we && (state_q == S_IDLE) && (int'(bus.buf_waddr) < NUM_WORDS)) begin
      mem_q[bus.buf_waddr] <= bus.buf_wdata;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      interrupt_q   <= 1'b0;
      length_q      <= '0;
      dev_data_q    <= '0;
      dev_beat_q    <= '0;
      dev_wr_req_q  <= 1'b0;
      block_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      base_q        <= '0;
      blocks_sent_q <= '0;
      need_low_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      interrupt_q   <= interrupt_d;
      length_q      <= length_d;
      dev_data_q    <= dev_data_d;
      dev_beat_q    <= dev_beat_d;
      dev_wr_req_q  <= dev_wr_req_d;
      block_done_q  <= block_done_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      base_q        <= base_d;
      blocks_sent_q <= blocks_sent_d;
      need_low_q    <= need_low_d;
    end
  end

  // Next-state and next-output logic; all outputs are registered copies
  always_comb begin
    state_d       = state_q;
    interrupt_d   = 1'b0;
    length_d      = length_q;
    dev_data_d    = dev_data_q;
    dev_beat_d    = dev_beat_q;
    dev_wr_req_d  = 1'b0;
    block_done_d  = 1'b0;
    err_d         = err_q;
    base_d        = base_q;
    blocks_sent_d = blocks_sent_q;
    need_low_d    = need_low_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d       = S_IRQ;
          interrupt_d   = 1'b1;
          length_d      = WORD_SIZE'(NUM_WORDS);
          blocks_sent_d = '0;
        end
      end

      S_IRQ: begin
        state_d    = S_WAIT_GNT;
        need_low_d = bus.bg;
      end

      S_WAIT_GNT: begin
        if (need_low_q) begin
          if (!bus.bg) need_low_d = 1'b0;
        end else if (bus.bg) begin
          state_d = S_SYNC;
        end
      end

      // Offset is valid now; latch it and either start or reject the block
      S_SYNC: begin
        base_d     = w_sync_addr;
        dev_beat_d = '0;
        if (w_out_of_range) begin
          err_d        = 1'b1;
          block_done_d = 1'b1;
          state_d      = S_DONE_BLK;
        end else begin
          dev_data_d   = mem_q[w_sync_addr];
          dev_wr_req_d = 1'b1;
          state_d      = S_XFER;
        end
      end

      // Final-beat acceptance wins over a falling bg in the same cycle.
      // After a non-final ack the request drops for one cycle while the
      // next word is set up, so memory never sees a stale request.
      S_XFER: begin
        if (w_accept && w_last_beat) begin
          block_done_d  = 1'b1;
          blocks_sent_d = blocks_sent_q + BLK_W'(1);
          state_d       = S_DONE_BLK;
        end else if (!bus.bg) begin
          need_low_d = 1'b0;
          state_d    = S_WAIT_GNT;
        end else if (w_accept) begin
          dev_beat_d = dev_beat_q + 2'd1;
          dev_data_d = mem_q[w_next_addr];
        end else begin
          dev_wr_req_d = 1'b1;
        end
      end

      S_DONE_BLK: begin
        if (blocks_sent_q == BLK_W'(NUM_BLOCKS)) begin
          length_d = '0;
          state_d  = S_IDLE;
        end else begin
          need_low_d = bus.bg;
          state_d    = S_WAIT_GNT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.interrupt  = interrupt_q;
  assign bus.length     = length_q;
  assign bus.dev_data   = dev_data_q;
  assign bus.dev_beat   = dev_beat_q;
  assign bus.dev_wr_req = dev_wr_req_q;
  assign bus.block_done = block_done_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_ext_device.sv
// ============================================================================
//  Module   : tb_dma_ext_device
//  Brief    : Directed self-checking bench for dma_ext_device.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dma_ext_device;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  dma_ext_device_if #(.WORD_SIZE(16), .NUM_WORDS(12)) bus ();

  dma_ext_device #(
    .WORD_SIZE  (16),
    .NUM_WORDS  (12),
    .BLOCK_WORDS(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One beat: wait for the request, check word and index, hold ack low for
  // `delay` cycles checking stability, then acknowledge for one cycle.
  task automatic do_beat(input logic [15:0] exp_data, input int exp_beat, input int delay);
    int n = 0;
    while (bus.dev_wr_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("req_seen", {31'd0, bus.dev_wr_req}, 32'd1);
    chk("dev_data", {16'd0, bus.dev_data}, {16'd0, exp_data});
    chk("dev_beat", {30'd0, bus.dev_beat}, exp_beat);
    for (int k = 0; k < delay; k++) begin
      tick();
      chk("hold_req",  {31'd0, bus.dev_wr_req}, 32'd1);
      chk("hold_data", {16'd0, bus.dev_data}, {16'd0, exp_data});
      chk("hold_beat", {30'd0, bus.dev_beat}, exp_beat);
    end
    bus.dev_wr_ack = 1'b1;
    tick();
    bus.dev_wr_ack = 1'b0;
  endtask

  // Full block under one grant; leaves bg low and one cycle past DONE_BLK
  task automatic run_block(input int off, input int slow_beat, input int slow_delay);
    bus.bg     = 1'b1;
    bus.offset = 16'(off);
    tick();
    chk("sync_no_req", {31'd0, bus.dev_wr_req}, 32'd0);
    for (int b = 0; b < 4; b++) begin
      do_beat(16'hA000 + 16'(off + b), b, (b == slow_beat) ? slow_delay : 1);
    end
    chk("block_done", {31'd0, bus.block_done}, 32'd1);
    chk("req_drop",   {31'd0, bus.dev_wr_req}, 32'd0);
    bus.bg = 1'b0;
    tick();
    chk("block_done_pulse", {31'd0, bus.block_done}, 32'd0);
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("interrupt", {31'd0, bus.interrupt}, 32'd1);
    chk("length",    {16'd0, bus.length}, 32'd12);
    chk("busy_run",  {31'd0, bus.busy}, 32'd1);
    tick();
    chk("interrupt_pulse", {31'd0, bus.interrupt}, 32'd0);
    chk("length_hold",     {16'd0, bus.length}, 32'd12);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.buf_we     = 1'b0;
    bus.buf_waddr  = '0;
    bus.buf_wdata  = '0;
    bus.bg         = 1'b0;
    bus.offset     = '0;
    bus.dev_wr_ack = 1'b0;
    tick();
    tick();
    chk("rst_interrupt", {31'd0, bus.interrupt}, 32'd0);
    chk("rst_req",       {31'd0, bus.dev_wr_req}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy}, 32'd0);
    chk("rst_err",       {31'd0, bus.err}, 32'd0);
    chk("rst_length",    {16'd0, bus.length}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Load buffer
    for (int i = 0; i < 12; i++) begin
      bus.buf_we    = 1'b1;
      bus.buf_waddr = 4'(i);
      bus.buf_wdata = 16'hA000 + 16'(i);
      tick();
    end
    bus.buf_we = 1'b0;

    // Run 1: offsets 8,4,0; bg left high after the first block must not
    // start another block until it has fallen
    start_run();
    bus.bg     = 1'b1;
    bus.offset = 16'd8;
    tick();
    for (int b = 0; b < 4; b++) do_beat(16'hA008 + 16'(b), b, 1);
    chk("blk8_done", {31'd0, bus.block_done}, 32'd1);
    bus.offset = 16'd4;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("regrant_blocked", {31'd0, bus.dev_wr_req}, 32'd0);
    end
    bus.bg = 1'b0;
    tick();
    run_block(4, -1, 0);
    run_block(0, -1, 0);
    chk("run1_idle", {31'd0, bus.busy}, 32'd0);

    // Run 2: slow ack on beat 1, then an aborted and replayed block
    start_run();
    run_block(0, 1, 5);
    bus.bg     = 1'b1;
    bus.offset = 16'd4;
    tick();
    do_beat(16'hA004, 0, 1);
    do_beat(16'hA005, 1, 1);
    bus.bg = 1'b0;
    tick();
    chk("abort_req",  {31'd0, bus.dev_wr_req}, 32'd0);
    chk("abort_done", {31'd0, bus.block_done}, 32'd0);
    tick();
    chk("abort_req2", {31'd0, bus.dev_wr_req}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd1);
    run_block(4, -1, 0);
    run_block(8, -1, 0);
    chk("run2_idle", {31'd0, bus.busy}, 32'd0);

    // Run 3: out-of-range offset sets err and completes without writes
    start_run();
    bus.bg     = 1'b1;
    bus.offset = 16'd12;
    tick();
    chk("err_sync_req", {31'd0, bus.dev_wr_req}, 32'd0);
    tick();
    chk("err_set",      {31'd0, bus.err}, 32'd1);
    chk("err_done",     {31'd0, bus.block_done}, 32'd1);
    chk("err_no_req",   {31'd0, bus.dev_wr_req}, 32'd0);
    bus.bg = 1'b0;
    tick();
    run_block(0, -1, 0);
    run_block(4, -1, 0);
    chk("err_busy", {31'd0, bus.busy}, 32'd1);
    run_block(8, -1, 0);
    chk("run3_idle",   {31'd0, bus.busy}, 32'd0);
    chk("err_sticky",  {31'd0, bus.err}, 32'd1);

    // Run 4: asynchronous reset in the middle of a transfer
    start_run();
    bus.bg     = 1'b1;
    bus.offset = 16'd0;
    tick();
    tick();
    chk("pre_rst_req", {31'd0, bus.dev_wr_req}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_req",  {31'd0, bus.dev_wr_req}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_err",  {31'd0, bus.err}, 32'd0);
    chk("arst_len",  {16'd0, bus.length}, 32'd0);
    chk("arst_data", {16'd0, bus.dev_data}, 32'd0);
    chk("arst_beat", {30'd0, bus.dev_beat}, 32'd0);
    bus.bg = 1'b0;
    tick();
    tick();
    chk("rst_hold_req", {31'd0, bus.dev_wr_req}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Run 5: normal run after reset, buffer contents retained
    start_run();
    run_block(8, -1, 0);
    run_block(4, -1, 0);
    run_block(0, -1, 0);
    chk("run5_idle", {31'd0, bus.busy}, 32'd0);
    chk("run5_err",  {31'd0, bus.err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
